// File: rtl/sandhi_issue_arbiter_if.sv
// Issue-side bundle between two instruction streams, the sandhi arbiter and the
// shared panini_decoder, including the tagged-result and status outputs.
interface sandhi_issue_arbiter_if #(
   parameter int INSTR_WIDTH = 32
);
   logic                   req0_valid;
   logic [INSTR_WIDTH-1:0] req0_instr;
   logic                   req0_ready;
   logic                   req1_valid;
   logic [INSTR_WIDTH-1:0] req1_instr;
   logic                   req1_ready;
   logic [INSTR_WIDTH-1:0] instruction;
   logic                   instr_valid;
   logic                   decode_valid;
   logic                   res_valid;
   logic                   res_owner;
   logic                   res_fused;
   logic                   lock_active;
   logic                   lock_timeout;
   logic                   order_error;

   // Requesters plus decoder side: drives requests and decode_valid.
   modport master (
      output req0_valid, req0_instr, req1_valid, req1_instr, decode_valid,
      input  req0_ready, req1_ready, instruction, instr_valid,
             res_valid, res_owner, res_fused, lock_active, lock_timeout, order_error
   );

   modport slave (
      input  req0_valid, req0_instr, req1_valid, req1_instr, decode_valid,
      output req0_ready, req1_ready, instruction, instr_valid,
             res_valid, res_owner, res_fused, lock_active, lock_timeout, order_error
   );
endinterface

// File: rtl/sandhi_issue_arbiter.sv
// Round-robin issue arbiter sharing one decoder between two streams; locks onto a
// requester after a LUI/ADDI opener so the pair reaches the decoder back-to-back.
module sandhi_issue_arbiter #(
   parameter int INSTR_WIDTH  = 32,
   parameter int LOCK_TIMEOUT = 4
) (
   input logic                   clk,
   input logic                   rst_n,
   sandhi_issue_arbiter_if.slave bus
);

   localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_ARB   = 2'd0,
      ST_LOCK0 = 2'd1,
      ST_LOCK1 = 2'd2
   } stateT;

   stateT                  r_state, w_stateNext;
   logic                   r_rrPtr, w_rrPtrNext;
   logic [CNT_W-1:0]       r_cnt, w_cntNext, w_cntDec;
   logic [4:0]             r_lockRd, w_lockRdNext;
   logic                   r_lockLui, w_lockLuiNext;

   logic                   w_grant0, w_grant1;
   logic                   w_ready0, w_ready1;
   logic                   w_hs, w_hsOwner;
   logic [INSTR_WIDTH-1:0] w_hsInstr;
   logic                   w_isLui, w_isAddi, w_isOpener;
   logic                   w_fused, w_timeout;

   logic [INSTR_WIDTH-1:0] r_issInstr;
   logic                   r_issValid, r_issOwner, r_issFused;
   logic                   r_resValid, r_resOwner, r_resFused;
   logic                   r_lockTimeout, r_orderError;

   // A lock grants only its owner; otherwise round-robin breaks ties.
   always_comb begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
      case (r_state)
         ST_LOCK0: w_grant0 = 1'b1;
         ST_LOCK1: w_grant1 = 1'b1;
         default: begin
            if (bus.req0_valid && bus.req1_valid) begin
               w_grant0 = !r_rrPtr;
               w_grant1 = r_rrPtr;
            end else begin
               w_grant0 = bus.req0_valid;
               w_grant1 = bus.req1_valid;
            end
         end
      endcase
   end

   assign w_ready0   = w_grant0 && bus.req0_valid;
   assign w_ready1   = w_grant1 && bus.req1_valid;
   assign w_hs       = w_ready0 || w_ready1;
   assign w_hsOwner  = w_ready1;
   assign w_hsInstr  = w_ready1 ? bus.req1_instr : bus.req0_instr;
   assign w_isLui    = (w_hsInstr[6:0] == 7'b0110111);
   assign w_isAddi   = (w_hsInstr[6:0] == 7'b0010011) && (w_hsInstr[14:12] == 3'b000);
   assign w_isOpener = w_isLui || w_isAddi;
   assign w_cntDec   = r_cnt - CNT_W'(1);

   // The lock expires on the edge where the countdown reaches 1, so the pulse and
   // the return to ARB both land LOCK_TIMEOUT cycles after the opener handshake.
   always_comb begin
      w_stateNext   = r_state;
      w_rrPtrNext   = r_rrPtr;
      w_cntNext     = r_cnt;
      w_lockRdNext  = r_lockRd;
      w_lockLuiNext = r_lockLui;
      w_fused       = 1'b0;
      w_timeout     = 1'b0;
      case (r_state)
         ST_ARB: begin
            if (w_hs) begin
               if (w_isOpener) begin
                  w_stateNext   = w_hsOwner ? ST_LOCK1 : ST_LOCK0;
                  w_cntNext     = CNT_W'(LOCK_TIMEOUT);
                  w_lockRdNext  = w_hsInstr[11:7];
                  w_lockLuiNext = w_isLui;
               end else begin
                  w_rrPtrNext = !w_hsOwner;
               end
            end
         end
         default: begin
            if (w_hs) begin
               w_stateNext = ST_ARB;
               w_rrPtrNext = !w_hsOwner;
               w_fused     = r_lockLui && w_isAddi && (w_hsInstr[19:15] == r_lockRd);
            end else begin
               w_cntNext = w_cntDec;
               if ((r_cnt <= CNT_W'(1)) || (w_cntDec == CNT_W'(1))) begin
                  w_timeout   = 1'b1;
                  w_stateNext = ST_ARB;
                  w_rrPtrNext = (r_state == ST_LOCK0);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_ARB;
         r_rrPtr   <= 1'b0;
         r_cnt     <= '0;
         r_lockRd  <= '0;
         r_lockLui <= 1'b0;
      end else begin
         r_state   <= w_stateNext;
         r_rrPtr   <= w_rrPtrNext;
         r_cnt     <= w_cntNext;
         r_lockRd  <= w_lockRdNext;
         r_lockLui <= w_lockLuiNext;
      end
   end

   // Stage 1 feeds the decoder; stage 2 tags the result alongside decode_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_issInstr    <= '0;
         r_issValid    <= 1'b0;
         r_issOwner    <= 1'b0;
         r_issFused    <= 1'b0;
         r_resValid    <= 1'b0;
         r_resOwner    <= 1'b0;
         r_resFused    <= 1'b0;
         r_lockTimeout <= 1'b0;
         r_orderError  <= 1'b0;
      end else begin
         r_issValid <= w_hs;
         if (w_hs) begin
            r_issInstr <= w_hsInstr;
            r_issOwner <= w_hsOwner;
            r_issFused <= w_fused;
         end
         r_resValid    <= r_issValid;
         r_resOwner    <= r_issOwner;
         r_resFused    <= r_issFused && r_issValid;
         r_lockTimeout <= w_timeout;
         r_orderError  <= (bus.decode_valid != r_resValid);
      end
   end

   assign bus.req0_ready   = w_ready0;
   assign bus.req1_ready   = w_ready1;
   assign bus.instruction  = r_issInstr;
   assign bus.instr_valid  = r_issValid;
   assign bus.res_valid    = r_resValid;
   assign bus.res_owner    = r_resOwner;
   assign bus.res_fused    = r_resFused;
   assign bus.lock_active  = (r_state != ST_ARB);
   assign bus.lock_timeout = r_lockTimeout;
   assign bus.order_error  = r_orderError;

endmodule

// File: doc/sandhi_issue_arbiter.md
# sandhi_issue_arbiter

Two-requester issue arbiter that shares the single `panini_decoder` between two instruction streams (e.g. two harts or fetch queues). It uses round-robin arbitration. When the granted instruction can open a sandhi pair (LUI, or ADDI with funct3=000), the grant locks onto that requester so its next instruction reaches the decoder back-to-back. It registers the issue into the decoder, tags each decoded result with its owner and a fused-pair flag aligned to `decode_valid`, and flags ordering errors.

## Interface
Parameters:
- `INSTR_WIDTH`, 32: instruction width.
- `LOCK_TIMEOUT`, 4: cycles a sandhi lock waits for the next instruction from the locked requester; must be ≥1.

Ports:
- `clk`  in  1  clock; everything is sampled on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 has an instruction.
- `req0_instr`  in  INSTR_WIDTH  requester 0 instruction.
- `req0_ready`  out  1  requester 0 handshake accepted this cycle (combinational).
- `req1_valid`  in  1  requester 1 has an instruction.
- `req1_instr`  in  INSTR_WIDTH  requester 1 instruction.
- `req1_ready`  out  1  requester 1 handshake accepted this cycle (combinational).
- `instruction`  out  INSTR_WIDTH  to decoder `instruction` (registered).
- `instr_valid`  out  1  to decoder `instr_valid` (registered).
- `decode_valid`  in  1  from decoder.
- `res_valid`  out  1  tag stage valid, expected coincident with `decode_valid`.
- `res_owner`  out  1  requester that owns the current decoded result.
- `res_fused`  out  1  current result is the second half of a fused LUI→ADDI pair.
- `lock_active`  out  1  FSM is in LOCK0 or LOCK1.
- `lock_timeout`  out  1  one-cycle pulse when a lock expires.
- `order_error`  out  1  one-cycle pulse when `decode_valid != res_valid`.

## Operation
- **FSM states:** ARB, LOCK0, LOCK1. Round-robin pointer `rr_ptr` (0/1). Timeout counter width is clog2(LOCK_TIMEOUT+1).
- **Grant in ARB:**
  - Both valid: grant `rr_ptr`.
  - One valid: grant that requester.
  - None valid: no grant.
- **Grant in LOCKn:** only requester n may be granted. The other requester's ready is 0 even if it is valid.
- **Handshake:** `reqN_ready` = grant to N AND `reqN_valid`. At most one ready per cycle. The decoder has no backpressure, so every handshake issues.
- **Opener:** opcode[6:0] = 0110111 (LUI), or opcode = 0010011 with funct3 = 000 (ADDI).
- **Handshake of an opener in ARB:**
  - Go to LOCKn.
  - Load the counter with LOCK_TIMEOUT.
  - Store the opener's rd[11:7] and an is_lui bit.
  - Leave `rr_ptr` unchanged.
- **Non-opener handshake in ARB:** `rr_ptr` ← other requester. State stays ARB.
- **Handshake in LOCKn** (second instruction; never re-locks, even if it is itself an opener):
  - Go to ARB.
  - `rr_ptr` ← other requester.
  - Mark fused if the stored is_lui=1, the instruction is ADDI (funct3=000), and rs1[19:15] equals the stored rd.
- **No handshake in LOCKn:**
  - Decrement the counter.
  - When the counter reaches 1 and still no handshake: pulse `lock_timeout`, go to ARB, `rr_ptr` ← other requester.
  - LOCK therefore lasts at most LOCK_TIMEOUT cycles.
- **Tag pipeline:**
  - Stage 1 (issue regs) captures instruction, valid, owner and fused.
  - Stage 2 (`res_*`) captures stage 1 every cycle. Its valid is cleared when stage 1 is invalid.
- **`lock_active`:** combinational from state.

## Timing
- **Reset values:**
  - All registered outputs are 0: `instruction`, `instr_valid`, `res_valid`, `res_owner`, `res_fused`, `lock_timeout`, `order_error`.
  - State = ARB, `rr_ptr` = 0, counter = 0, stored rd = 0.
  - `lock_active` = 0; ready outputs are 0 unless a request is valid.
- **Latency:**
  - Handshake at cycle T → `instr_valid` at T+1.
  - `decode_valid` and `res_valid` at T+2.
  - Sustained throughput is 1 instruction/cycle.
- **Lock timing:** the lock decision uses the instruction at the handshake edge, so the lock is in effect from T+1. A timeout pulse occurs in the cycle the FSM returns to ARB, and the other requester can be granted in that same cycle.
- **Simultaneous events:**
  - The locked requester becoming valid on the final timeout cycle wins: it handshakes and no timeout pulse occurs.
  - Both requesters valid in LOCKn: only n is served.
- **Error check:** `order_error` is registered one cycle after the mismatch.
- **Reset mid-operation:**
  - An asynchronous reset drops any lock and clears the in-flight stage-1 and stage-2 entries.
  - After release, arbitration restarts at requester 0.

## Test plan
- **Both requesters valid with non-openers** (ADD 0x002081B3) for 6 cycles → grants 0,1,0,1,0,1; `res_owner` follows the same order at T+2; `order_error` = 0.
- **req0 LUI x5 (0x000122B7) then ADDI x5,x5,1 (0x00128293), req1 always valid** → req0, req0, then req1; `res_fused` = 1 only on the second req0 result; `lock_active` high for 1 cycle.
- **req0 LUI x5 then ADDI x6,x7,1 (rs1 ≠ 5)** → the lock still pairs the two instructions back-to-back, but `res_fused` = 0.
- **LOCK_TIMEOUT = 4, req0 LUI then req0_valid low, req1 valid** → `lock_timeout` pulses 4 cycles after the LUI handshake; req1 is granted in that cycle.
- **`rst_n` asserted during LOCK0 with an instruction in flight** → all outputs 0 immediately; after release, with both requesters valid, req0 is granted first and there are no stale `res_valid` pulses.
- **Force `decode_valid` = 0 when `res_valid` = 1** → `order_error` pulses once, one cycle later.
